// File: rtl/key_display_ctrl.sv
// key_display_ctrl: keypad event capture, hex decode, two-digit history and a
// time-multiplexed dual seven-segment display (common anode, active-low).
// Optional build macro: MULTI_KEY_REJECT_EN. When it is defined, events whose rows or
// cols are not exactly one-hot are discarded. When it is undefined, such events are
// priority-encoded with the lowest index winning.
//
// Handshake: new_num is a valid-only pulse with no ready. It is accepted only in IDLE.
// A pulse that arrives while the controller is in CAPTURE or COMMIT is dropped and is
// not queued. key_valid is a single-cycle pulse in the COMMIT cycle, and digits takes
// the new value on the edge that closes that cycle.
module key_display_ctrl #(
    parameter int MUX_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_num,
    input  logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [7:0] digits,
    output logic       key_valid,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [1:0] o_dbg_state
);

    localparam int CW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, COMMIT = 2'd2} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic   [3:0]  r_rows;
    logic   [3:0]  r_cols;
    logic   [7:0]  r_digits;
    logic   [CW-1:0] r_cnt;
    logic          r_sel;
    logic   [1:0]  w_row_idx;
    logic   [1:0]  w_col_idx;
    logic   [3:0]  w_key;
    logic          w_snap_ok;
    logic          w_load;
    logic          w_commit;
    logic   [3:0]  w_disp_val;

    // Priority-encode the snapshot so that the lowest set bit wins.
    always_comb begin
        w_row_idx = 2'd0;
        w_col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_rows[i]) w_row_idx = 2'(i);
            if (r_cols[i]) w_col_idx = 2'(i);
        end
    end

    // Decide whether the snapshot may be committed.
`ifdef MULTI_KEY_REJECT_EN
    assign w_snap_ok = (r_rows != 4'd0) && ((r_rows & (r_rows - 4'd1)) == 4'd0) &&
                       (r_cols != 4'd0) && ((r_cols & (r_cols - 4'd1)) == 4'd0);
`else
    assign w_snap_ok = (r_rows != 4'd0) && (r_cols != 4'd0);
`endif

    // Map (row, col) to the hex value printed on the keypad.
    always_comb begin
        w_key = 4'h0;
        case ({w_row_idx, w_col_idx})
            4'b00_00: w_key = 4'h1;
            4'b00_01: w_key = 4'h2;
            4'b00_10: w_key = 4'h3;
            4'b00_11: w_key = 4'hA;
            4'b01_00: w_key = 4'h4;
            4'b01_01: w_key = 4'h5;
            4'b01_10: w_key = 4'h6;
            4'b01_11: w_key = 4'hB;
            4'b10_00: w_key = 4'h7;
            4'b10_01: w_key = 4'h8;
            4'b10_10: w_key = 4'h9;
            4'b10_11: w_key = 4'hC;
            4'b11_00: w_key = 4'hE;
            4'b11_01: w_key = 4'h0;
            4'b11_10: w_key = 4'hF;
            default:  w_key = 4'hD;
        endcase
    end

    // Register the FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Compute the next state and the per-state strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (new_num) begin
                    w_load       = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: w_next_state = w_snap_ok ? COMMIT : IDLE;
            COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Hold the event snapshot and shift committed keys into the history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rows   <= 4'd0;
            r_cols   <= 4'd0;
            r_digits <= 8'h00;
        end else begin
            if (w_load) begin
                r_rows <= rows;
                r_cols <= cols;
            end
            if (w_commit) r_digits <= {r_digits[3:0], w_key};
        end
    end

    // Run the free-running digit-select counter, which is independent of the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
        end else if (r_cnt == CW'(MUX_DIV - 1)) begin
            r_cnt <= '0;
            r_sel <= ~r_sel;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Select the active digit and drive the shared hex-to-segment decoder.
    always_comb begin
        an         = r_sel ? 2'b01 : 2'b10;
        w_disp_val = r_sel ? r_digits[7:4] : r_digits[3:0];
        seg        = 7'h40;
        case (w_disp_val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

    assign digits      = r_digits;
    assign key_valid   = w_commit;
    assign o_dbg_state = r_state;

endmodule

// File: doc/key_display_ctrl.md
Name: key_display_ctrl

Overview:
Controller between the matrix keypad scanner and a dual common-anode seven-segment display.
- Captures each key event pulsed by the scanner and decodes the row/column pair to a hex value.
- Shifts the value into a two-digit history.
- Time-multiplexes one shared hex-to-segment decoder between the two digits.

Parameters:
MUX_DIV, 1000, clock cycles each digit is driven before the display select toggles (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
new_num  input  1  single-cycle key-event pulse from scanner; rows/cols valid in the same cycle
rows  input  4  scanner row drive at event (one-hot expected)
cols  input  4  keypad column sense at event (one-hot expected)
digits  output  8  [3:0] most recent key, [7:4] previous key
key_valid  output  1  one-cycle pulse when a key is committed to digits
seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}
an  output  2  active-low anode enables; an[0] drives digit 0 (recent), an[1] drives digit 1 (previous)

Behaviour:
- Reset values (async, while reset=0): state=IDLE, digits=8'h00, key_valid=0, mux counter=0, sel=0, an=2'b10, seg=7'h40.
- Keymap by (row index, col index):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states are IDLE, CAPTURE and COMMIT.
- IDLE:
  - If new_num=1, register rows and cols into a snapshot and go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE:
  - Decode the snapshot into a 4-bit key and a valid flag.
  - If the snapshot cols==0 or rows==0, the event is discarded: return to IDLE.
  - Otherwise go to COMMIT.
- COMMIT:
  - key_valid=1 for exactly this cycle.
  - At the closing edge, digits <= {digits[3:0], key}.
  - Go to IDLE.
- Latency: new_num at cycle N → key_valid high in cycle N+2; digits shows the new value from cycle N+3.
- new_num asserted while in CAPTURE or COMMIT is ignored; no queueing.
- Without MULTI_KEY_REJECT_EN, when several bits are set, the lowest-index set bit wins for both rows and cols (priority encode).
- Display mux:
  - The free-running counter counts 0..MUX_DIV-1.
  - On the wrap cycle (counter==MUX_DIV-1) the counter returns to 0 and sel toggles at that edge.
  - sel=0: an=2'b10 and the decoder input is digits[3:0].
  - sel=1: an=2'b01 and the decoder input is digits[7:4].
  - an and seg are combinational from sel and digits, so a commit is visible on the active digit in the same cycle that digits updates.
- Hex-to-segment encoding (active-low, hex value of seg):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Reset mid-operation: asserting reset in CAPTURE or COMMIT aborts the commit. digits returns to 8'h00 and no key_valid is produced.
- The counter and FSM are independent: a commit coinciding with a mux wrap causes both to take effect in the same cycle.

Optional Feature:
MULTI_KEY_REJECT_EN
- Defined: in CAPTURE, the snapshot is discarded (return to IDLE, no key_valid, digits unchanged) unless both rows and cols are exactly one-hot.
- Undefined: multi-bit rows or cols are priority-encoded (lowest index) and committed. Only zero rows or zero cols are discarded.

Test Plan:
- Reset, then hold 2*MUX_DIV cycles → digits=00, key_valid never high, an alternates 10/01 every MUX_DIV cycles, seg=40 throughout.
- new_num with rows=0001, cols=0010 (key 2), then rows=0100, cols=0001 (key 7) → two key_valid pulses each 2 cycles after new_num. digits=8'h27 after the second commit; seg=24 when an=01 and 78 when an=10.
- new_num with rows=1000, cols=0001 → digits[3:0]=E. new_num with rows=1000, cols=0100 → digits=8'hEF, seg=0E on digit 0.
- new_num with cols=0000 → no key_valid, digits unchanged. A new_num pulse in the cycle after an accepted event → ignored, only one commit.
- new_num with rows=0010, cols=0110:
  - With MULTI_KEY_REJECT_EN: discarded, digits unchanged.
  - Without it: key 5 committed.
- Assert reset during the COMMIT cycle after key 9 → key_valid=0 immediately, digits=00. After release, the next event commits normally.
